glb_ld_dma_addr_gen: RTL
========================

// Module: glb_ld_dma_addr_gen
// PURPOSE
// - Load-DMA address generator of a GLB tile: consumes a dma_ld_header_t and emits rdrq_packet_t
//   read requests toward the bank read-request router, one word per accepted beat.
// - Walks a LOOP_LEVEL-deep nested loop (level 0 innermost) with optional active/inactive duty gaps.
// - Sits between the tile config registers (header source) and the rdrq router (request sink).
// PARAMETERS
// - GLB_ADDR_WIDTH      22  byte address width of rdrq_addr
// - MAX_NUM_WORDS_WIDTH 16  width of range, num_active_words, num_inactive_words
// - MAX_STRIDE_WIDTH    10  width of each loop stride (bytes, unsigned)
// - LOOP_LEVEL          3   number of nested loop levels
// PORTS
// - clk                   in   1                        clock
// - rst_n                 in   1                        async active-low reset
// - dma_mode              in   2                        00 OFF, 01 NORMAL, 10 REPEAT, 11 AUTO_INCR
// - ld_start              in   1                        one-cycle start pulse
// - ld_header             in   dma_ld_header_t          valid, start_addr, iteration[LOOP_LEVEL], num_active/inactive_words
// - rdrq_en               out  1                        request valid (rdrq_packet_t.rd_en)
// - rdrq_addr             out  GLB_ADDR_WIDTH           request byte address (rdrq_packet_t.rd_addr)
// - rdrq_ready            in   1                        sink accepts request this cycle
// - ld_busy               out  1                        run in progress
// - ld_done_pulse         out  1                        one-cycle pulse after last accepted request
// BEHAVIOUR
// - Reset (async assert, sync deassert): state IDLE; rdrq_en=0, rdrq_addr=0, ld_busy=0, ld_done_pulse=0; all counters 0.
// - States: IDLE, ACTIVE, INACTIVE, DONE.
// - IDLE->ACTIVE: ld_start=1 and ld_header.valid=1 and dma_mode!=OFF; header captured into internal regs that cycle.
//   ld_start with valid=0 or mode OFF ignored; ld_start while ld_busy=1 ignored.
// - Latency: ld_start at cycle T -> first rdrq_en=1 at T+1 with rdrq_addr=start_addr.
// - Handshake: beat transfers when rdrq_en&&rdrq_ready; while rdrq_en=1 and !rdrq_ready, rdrq_addr held stable.
// - Address: addr = start_addr + sum(itr[k]*stride[k]), modulo 2^GLB_ADDR_WIDTH; itr[0] increments per beat,
//   itr[k] wraps at range[k]-1 and carries into itr[k+1]; per-level base registers, no multipliers.
// - Total beats = product of range[k]; any range[k]==0 -> zero beats: ACTIVE->DONE immediately, no rdrq_en.
// - Duty: after num_active_words consecutive beats, if num_inactive_words!=0 go INACTIVE for exactly
//   num_inactive_words cycles (rdrq_en=0), then ACTIVE. num_active_words==0 or num_inactive_words==0 -> no gaps.
//   Last beat of run takes priority: ACTIVE->DONE, never INACTIVE.
// - DONE: ld_done_pulse=1 for one cycle, then NORMAL/AUTO_INCR -> IDLE; REPEAT -> ACTIVE on next cycle
//   with captured header (first beat one cycle after pulse); dma_mode==OFF sampled in DONE forces IDLE.
// - AUTO_INCR: on DONE, captured start_addr <= last issued addr + BANK_DATA_WIDTH/8 (8); next ld_start uses
//   this value instead of ld_header.start_addr (header still required valid).
// - ld_busy=1 in ACTIVE, INACTIVE, DONE.
// - dma_mode change mid-run has no effect until DONE.
// CONFIGURATION
// - GLB_LD_DMA_STALL_CNT_EN defined: adds output stall_cnt[31:0]; counts cycles with rdrq_en&&!rdrq_ready,
//   cleared on accepted ld_start and reset, saturates at 2^32-1, holds after DONE.
// - Undefined: port and counter absent; all other behaviour identical.
// TESTING
// - NORMAL, start=0x100, range={4,1,1}, stride0=8, ready=1 -> addrs 0x100,0x108,0x110,0x118 on T+1..T+4, done at T+5.
// - range={2,3,1}, stride={8,0x40}, start=0 -> 0x0,0x8,0x40,0x48,0x80,0x88, then single done pulse.
// - active=2, inactive=3, range0=4 -> 2 beats, 3 idle cycles, 2 beats, done; no gap after last beat.
// - ready low 5 cycles on beat 2 -> rdrq_addr stable, stall_cnt=5 (with EN); no address skipped.
// - range1=0 -> no rdrq_en, ld_done_pulse at T+2; REPEAT -> runs restart until dma_mode=OFF, then IDLE.
// - rst_n low mid-ACTIVE -> outputs 0 immediately; ld_start during busy ignored; AUTO_INCR 2nd run starts at last+8.

Source files
------------

// File: rtl/glb_ld_dma_addr_gen_if.sv
// Interface between the GLB load-DMA address generator and its environment.
// It carries the header source, the rdrq request channel and the status outputs.
// The optional stall counter output exists only when GLB_LD_DMA_STALL_CNT_EN is defined.
interface glb_ld_dma_if #(
    parameter int unsigned GLB_ADDR_WIDTH      = 22,
    parameter int unsigned MAX_NUM_WORDS_WIDTH = 16,
    parameter int unsigned MAX_STRIDE_WIDTH    = 10,
    parameter int unsigned LOOP_LEVEL          = 3
) ();

    typedef struct packed {
        logic [MAX_NUM_WORDS_WIDTH-1:0] range;
        logic [MAX_STRIDE_WIDTH-1:0]    stride;
    } loop_iter_t;

    typedef struct packed {
        logic                           valid;
        logic [GLB_ADDR_WIDTH-1:0]      start_addr;
        loop_iter_t [LOOP_LEVEL-1:0]    iteration;
        logic [MAX_NUM_WORDS_WIDTH-1:0] num_active_words;
        logic [MAX_NUM_WORDS_WIDTH-1:0] num_inactive_words;
    } dma_ld_header_t;

    logic [1:0]                dma_mode;
    logic                      ld_start;
    dma_ld_header_t            ld_header;
    logic                      rdrq_en;
    logic [GLB_ADDR_WIDTH-1:0] rdrq_addr;
    logic                      rdrq_ready;
    logic                      ld_busy;
    logic                      ld_done_pulse;
`ifdef GLB_LD_DMA_STALL_CNT_EN
    logic [31:0]               stall_cnt;

    modport master (
        input  dma_mode, ld_start, ld_header, rdrq_ready,
        output rdrq_en, rdrq_addr, ld_busy, ld_done_pulse, stall_cnt
    );

    modport slave (
        output dma_mode, ld_start, ld_header, rdrq_ready,
        input  rdrq_en, rdrq_addr, ld_busy, ld_done_pulse, stall_cnt
    );
`else
    modport master (
        input  dma_mode, ld_start, ld_header, rdrq_ready,
        output rdrq_en, rdrq_addr, ld_busy, ld_done_pulse
    );

    modport slave (
        output dma_mode, ld_start, ld_header, rdrq_ready,
        input  rdrq_en, rdrq_addr, ld_busy, ld_done_pulse
    );
`endif

endinterface

// File: rtl/glb_ld_dma_addr_gen.sv
// GLB tile load-DMA address generator.
// Captures a load header and walks a LOOP_LEVEL-deep nested loop (level 0 innermost),
// issuing one rdrq byte address per accepted beat, with optional active/inactive duty gaps.
// Modes: OFF, NORMAL, REPEAT (rerun captured header), AUTO_INCR (next run continues after
// the last issued word). Optional feature macro: GLB_LD_DMA_STALL_CNT_EN adds stall_cnt.
module glb_ld_dma_addr_gen #(
    parameter int unsigned GLB_ADDR_WIDTH      = 22,
    parameter int unsigned MAX_NUM_WORDS_WIDTH = 16,
    parameter int unsigned MAX_STRIDE_WIDTH    = 10,
    parameter int unsigned LOOP_LEVEL          = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    glb_ld_dma_if.master bus
);

    localparam int unsigned AW = GLB_ADDR_WIDTH;
    localparam int unsigned WW = MAX_NUM_WORDS_WIDTH;
    localparam int unsigned SW = MAX_STRIDE_WIDTH;
    localparam int unsigned LL = LOOP_LEVEL;
    // One bank word is BANK_DATA_WIDTH (64) bits.
    localparam int unsigned BANK_BYTES = 8;

    localparam logic [1:0] ModeOff      = 2'b00;
    localparam logic [1:0] ModeNormal   = 2'b01;
    localparam logic [1:0] ModeRepeat   = 2'b10;
    localparam logic [1:0] ModeAutoIncr = 2'b11;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StActive   = 2'd1;
    localparam logic [1:0] StInactive = 2'd2;
    localparam logic [1:0] StDone     = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [AW-1:0]         start_addr_q, start_addr_d;
    logic [LL-1:0][WW-1:0] range_q, range_d;
    logic [LL-1:0][SW-1:0] stride_q, stride_d;
    logic [WW-1:0]         act_q, act_d;
    logic [WW-1:0]         inact_q, inact_d;
    logic [LL-1:0][WW-1:0] itr_q, itr_d;
    // base_q[k]: address of the current level-k iteration with all lower levels at zero.
    logic [LL-1:0][AW-1:0] base_q, base_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [AW-1:0]         last_addr_q, last_addr_d;
    logic [WW-1:0]         act_cnt_q, act_cnt_d;
    logic [WW-1:0]         inact_cnt_q, inact_cnt_d;
    logic                  zero_q, zero_d;
    // Set once an AUTO_INCR run has completed, so start_addr_q holds the continuation address.
    logic                  auto_vld_q, auto_vld_d;

    logic                  rdrq_en;
    logic                  beat;
    logic                  last_beat;
    logic                  start_accept;
    logic                  hdr_zero;
    logic [LL-1:0]         wrap;
    logic [LL-1:0]         upd;
    logic                  found;
    logic [AW-1:0]         step_addr;
    logic [AW-1:0]         src_addr;

    assign rdrq_en      = (state_q == StActive) && !zero_q;
    assign beat         = rdrq_en && bus.rdrq_ready;
    assign start_accept = (state_q == StIdle) && bus.ld_start && bus.ld_header.valid &&
                          (bus.dma_mode != ModeOff);
    assign src_addr     = ((bus.dma_mode == ModeAutoIncr) && auto_vld_q) ? start_addr_q :
                          bus.ld_header.start_addr;

    // Per-level wrap flags of the running loop and zero-range detect on the incoming header.
    always_comb begin
        wrap     = '0;
        hdr_zero = 1'b0;
        for (int k = 0; k < LL; k++) begin
            wrap[k] = (itr_q[k] == range_q[k] - WW'(1));
            if (bus.ld_header.iteration[k].range == '0) begin
                hdr_zero = 1'b1;
            end
        end
        last_beat = &wrap;
    end

    // Next state, loop counters and address walk.
    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        range_d      = range_q;
        stride_d     = stride_q;
        act_d        = act_q;
        inact_d      = inact_q;
        itr_d        = itr_q;
        base_d       = base_q;
        addr_d       = addr_q;
        last_addr_d  = last_addr_q;
        act_cnt_d    = act_cnt_q;
        inact_cnt_d  = inact_cnt_q;
        zero_d       = zero_q;
        auto_vld_d   = auto_vld_q;
        upd          = '0;
        found        = 1'b0;
        step_addr    = addr_q;

        case (state_q)
            StIdle: begin
                if (start_accept) begin
                    for (int k = 0; k < LL; k++) begin
                        range_d[k]  = bus.ld_header.iteration[k].range;
                        stride_d[k] = bus.ld_header.iteration[k].stride;
                    end
                    act_d        = bus.ld_header.num_active_words;
                    inact_d      = bus.ld_header.num_inactive_words;
                    start_addr_d = src_addr;
                    if (bus.dma_mode != ModeAutoIncr) begin
                        auto_vld_d = 1'b0;
                    end
                    itr_d       = '0;
                    base_d      = {LL{src_addr}};
                    addr_d      = src_addr;
                    // A zero-beat AUTO_INCR run then leaves the continuation address unchanged.
                    last_addr_d = src_addr - AW'(BANK_BYTES);
                    act_cnt_d   = '0;
                    inact_cnt_d = '0;
                    zero_d      = hdr_zero;
                    state_d     = StActive;
                end
            end
            StActive: begin
                if (zero_q) begin
                    state_d = StDone;
                end else if (beat) begin
                    last_addr_d = addr_q;
                    if (last_beat) begin
                        state_d = StDone;
                    end else begin
                        // Carry through the wrapping levels into the first non-wrapping one.
                        for (int k = 0; k < LL; k++) begin
                            if (!found) begin
                                upd[k] = 1'b1;
                                if (wrap[k]) begin
                                    itr_d[k] = '0;
                                end else begin
                                    itr_d[k]  = itr_q[k] + WW'(1);
                                    step_addr = base_q[k] + AW'(stride_q[k]);
                                    found     = 1'b1;
                                end
                            end
                        end
                        for (int k = 0; k < LL; k++) begin
                            if (upd[k]) begin
                                base_d[k] = step_addr;
                            end
                        end
                        addr_d = step_addr;
                        if ((act_q != '0) && (inact_q != '0) &&
                            (act_cnt_q == act_q - WW'(1))) begin
                            act_cnt_d   = '0;
                            inact_cnt_d = '0;
                            state_d     = StInactive;
                        end else begin
                            act_cnt_d = act_cnt_q + WW'(1);
                        end
                    end
                end
            end
            StInactive: begin
                if (inact_cnt_q == inact_q - WW'(1)) begin
                    inact_cnt_d = '0;
                    state_d     = StActive;
                end else begin
                    inact_cnt_d = inact_cnt_q + WW'(1);
                end
            end
            StDone: begin
                if (bus.dma_mode == ModeAutoIncr) begin
                    start_addr_d = last_addr_q + AW'(BANK_BYTES);
                    auto_vld_d   = 1'b1;
                end
                if (bus.dma_mode == ModeRepeat) begin
                    itr_d       = '0;
                    base_d      = {LL{start_addr_q}};
                    addr_d      = start_addr_q;
                    last_addr_d = start_addr_q - AW'(BANK_BYTES);
                    act_cnt_d   = '0;
                    inact_cnt_d = '0;
                    state_d     = StActive;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            start_addr_q <= '0;
            range_q      <= '0;
            stride_q     <= '0;
            act_q        <= '0;
            inact_q      <= '0;
            itr_q        <= '0;
            base_q       <= '0;
            addr_q       <= '0;
            last_addr_q  <= '0;
            act_cnt_q    <= '0;
            inact_cnt_q  <= '0;
            zero_q       <= 1'b0;
            auto_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            range_q      <= range_d;
            stride_q     <= stride_d;
            act_q        <= act_d;
            inact_q      <= inact_d;
            itr_q        <= itr_d;
            base_q       <= base_d;
            addr_q       <= addr_d;
            last_addr_q  <= last_addr_d;
            act_cnt_q    <= act_cnt_d;
            inact_cnt_q  <= inact_cnt_d;
            zero_q       <= zero_d;
            auto_vld_q   <= auto_vld_d;
        end
    end

    assign bus.rdrq_en       = rdrq_en;
    assign bus.rdrq_addr     = addr_q;
    assign bus.ld_busy       = (state_q != StIdle);
    assign bus.ld_done_pulse = (state_q == StDone);

`ifdef GLB_LD_DMA_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of back-pressured request cycles, restarted by each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (start_accept) begin
            stall_cnt_q <= '0;
        end else if (rdrq_en && !bus.rdrq_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule
